i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address, byte-wide write/read handshake and open-drain SDA.
// Optional I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL and SDA.
module i2c_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] shift_d;
  logic [6:0] tx_q;
  logic       rw_q, ack_ph_q, sda_oe_q;
  logic [7:0] wr_data_q;
  logic       wr_valid_q, rd_req_q, busy_q;

  // Bus idles high, so the synchronizers reset high to avoid false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_flt_q  <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_flt_q  <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  // START/STOP need SCL high on both samples, so SDA moves while SCL is low never count.
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
  assign shift_d   = {shift_q, sda_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_q       <= 7'd0;
      rw_q       <= 1'b0;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_data_q  <= 8'h00;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= 4'd0;
        shift_q   <= 7'd0;
        ack_ph_q  <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (stop_det) begin
        state_q   <= IDLE;
        bit_cnt_q <= 4'd0;
        ack_ph_q  <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q <= shift_d[6:0];
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                rw_q      <= sda_c;
                ack_ph_q  <= 1'b0;
                state_q   <= (shift_d[7:1] == SLV_ADDR) ? ADDR_ACK : WAIT_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          // ack_ph_q marks that the ACK is on the bus and the 9th clock is in progress.
          ADDR_ACK: begin
            if (scl_fall && !ack_ph_q) begin
              sda_oe_q <= 1'b1;
              ack_ph_q <= 1'b1;
              busy_q   <= 1'b1;
            end else if (scl_rise && ack_ph_q && rw_q) begin
              rd_req_q <= 1'b1;
            end else if (scl_fall && ack_ph_q) begin
              ack_ph_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              if (rw_q) begin
                tx_q     <= rd_data[6:0];
                sda_oe_q <= ~rd_data[7];
                state_q  <= RD;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= WR;
              end
            end
          end
          WR: begin
            if (scl_rise) begin
              shift_q <= shift_d[6:0];
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q  <= 4'd0;
                wr_data_q  <= shift_d;
                wr_valid_q <= 1'b1;
                ack_ph_q   <= 1'b0;
                state_q    <= WR_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall && !ack_ph_q) begin
              sda_oe_q <= 1'b1;
              ack_ph_q <= 1'b1;
            end else if (scl_fall && ack_ph_q) begin
              sda_oe_q  <= 1'b0;
              ack_ph_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= WR;
            end
          end
          // Bit 7 went out on entry; each later fall presents the next bit.
          RD: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                ack_ph_q  <= 1'b0;
                state_q   <= RD_ACK;
              end else begin
                sda_oe_q <= ~tx_q[6];
                tx_q     <= {tx_q[5:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && !ack_ph_q) begin
              if (!sda_c) begin
                rd_req_q <= 1'b1;
                ack_ph_q <= 1'b1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= WAIT_STOP;
              end
            end else if (scl_fall && ack_ph_q) begin
              tx_q      <= rd_data[6:0];
              sda_oe_q  <= ~rd_data[7];
              ack_ph_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= RD;
            end
          end
          WAIT_STOP: sda_oe_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-level I2C master drives SCL/SDA with a pull-up on SDA.
module tb_i2c_slave;
  localparam int Q = 8;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       m_low;
  logic [7:0] rd_data;
  logic [7:0] wr_data;
  logic       wr_valid, rd_req, busy;
  wire        sda_w;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  assign sda_w = m_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_slave #(.SLV_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda_w),
    .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req),
    .rd_data(rd_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (wr_valid) wr_pulses <= wr_pulses + 1;
    if (rd_req)   rd_pulses <= rd_pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic drive_low, output logic sampled);
    m_low = drive_low;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sampled = sda_w;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic send_start();
    m_low = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    m_low = 1'b1;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic send_stop();
    m_low = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    m_low = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_level);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(~b[i], s);
    bus_bit(1'b0, ack_level);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b0, s);
      d[i] = s;
    end
    bus_bit(~nack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total_cnt++; if (sda_w !== 1'b1) $display("FAIL reset_sda: got %b expected 1", sda_w); else pass_cnt++;
    total_cnt++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h expected 00", wr_data); else pass_cnt++;
    total_cnt++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); else pass_cnt++;
    total_cnt++; if (rd_req !== 1'b0) $display("FAIL reset_rd_req: got %b expected 0", rd_req); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b0;
    tick(Q);
  endtask

  task automatic test_write();
    logic a;
    int w0;
    w0 = wr_pulses;
    send_start();
    write_byte(8'h84, a);
    total_cnt++; if (a !== 1'b0) $display("FAIL wr_addr_ack: got %b expected 0", a); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b expected 1", busy); else pass_cnt++;
    write_byte(8'hA5, a);
    total_cnt++; if (a !== 1'b0) $display("FAIL wr_data_ack: got %b expected 0", a); else pass_cnt++;
    send_stop();
    total_cnt++; if (wr_data !== 8'hA5) $display("FAIL wr_data: got %h expected a5", wr_data); else pass_cnt++;
    total_cnt++; if (wr_pulses - w0 !== 1) $display("FAIL wr_valid_count: got %0d expected 1", wr_pulses - w0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] d;
    int r0;
    r0 = rd_pulses;
    rd_data = 8'h3C;
    send_start();
    write_byte(8'h85, a);
    total_cnt++; if (a !== 1'b0) $display("FAIL rd_addr_ack: got %b expected 0", a); else pass_cnt++;
    total_cnt++; if (rd_pulses - r0 !== 1) $display("FAIL rd_req_first: got %0d expected 1", rd_pulses - r0); else pass_cnt++;
    rd_data = 8'hC3;
    read_byte(1'b0, d);
    total_cnt++; if (d !== 8'h3C) $display("FAIL rd_byte0: got %h expected 3c", d); else pass_cnt++;
    total_cnt++; if (rd_pulses - r0 !== 2) $display("FAIL rd_req_second: got %0d expected 2", rd_pulses - r0); else pass_cnt++;
    read_byte(1'b1, d);
    total_cnt++; if (d !== 8'hC3) $display("FAIL rd_byte1: got %h expected c3", d); else pass_cnt++;
    total_cnt++; if (rd_pulses - r0 !== 2) $display("FAIL rd_req_after_nack: got %0d expected 2", rd_pulses - r0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rd_busy_after_nack: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (sda_w !== 1'b1) $display("FAIL rd_sda_wait_stop: got %b expected 1", sda_w); else pass_cnt++;
    send_stop();
  endtask

  task automatic test_wrong_addr();
    logic a;
    int w0, r0;
    w0 = wr_pulses;
    r0 = rd_pulses;
    send_start();
    write_byte(8'h90, a);
    total_cnt++; if (a !== 1'b1) $display("FAIL na_no_ack: got %b expected 1", a); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL na_busy: got %b expected 0", busy); else pass_cnt++;
    write_byte(8'h00, a);
    send_stop();
    total_cnt++; if (wr_pulses - w0 !== 0) $display("FAIL na_wr_valid: got %0d expected 0", wr_pulses - w0); else pass_cnt++;
    total_cnt++; if (rd_pulses - r0 !== 0) $display("FAIL na_rd_req: got %0d expected 0", rd_pulses - r0); else pass_cnt++;
  endtask

  task automatic test_repeated_start();
    logic a;
    logic [7:0] d;
    int w0, r0;
    w0 = wr_pulses;
    r0 = rd_pulses;
    rd_data = 8'h5E;
    send_start();
    write_byte(8'h84, a);
    write_byte(8'h11, a);
    total_cnt++; if (a !== 1'b0) $display("FAIL rs_data_ack: got %b expected 0", a); else pass_cnt++;
    send_start();
    total_cnt++; if (busy !== 1'b0) $display("FAIL rs_busy_cleared: got %b expected 0", busy); else pass_cnt++;
    write_byte(8'h85, a);
    total_cnt++; if (a !== 1'b0) $display("FAIL rs_addr_ack: got %b expected 0", a); else pass_cnt++;
    read_byte(1'b1, d);
    send_stop();
    total_cnt++; if (d !== 8'h5E) $display("FAIL rs_read: got %h expected 5e", d); else pass_cnt++;
    total_cnt++; if (wr_data !== 8'h11) $display("FAIL rs_wr_data: got %h expected 11", wr_data); else pass_cnt++;
    total_cnt++; if (wr_pulses - w0 !== 1) $display("FAIL rs_wr_valid: got %0d expected 1", wr_pulses - w0); else pass_cnt++;
    total_cnt++; if (rd_pulses - r0 !== 1) $display("FAIL rs_rd_req: got %0d expected 1", rd_pulses - r0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic s, a;
    logic [7:0] b;
    b = 8'h84;
    send_start();
    for (int i = 7; i >= 0; i--) bus_bit(~b[i], s);
    m_low = 1'b0;
    tick(1);
    total_cnt++; if (sda_w !== 1'b0) $display("FAIL rm_ack_driven: got %b expected 0", sda_w); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (sda_w !== 1'b1) $display("FAIL rm_sda_release: got %b expected 1", sda_w); else pass_cnt++;
    tick(1);
    total_cnt++; if (wr_data !== 8'h00) $display("FAIL rm_wr_data: got %h expected 00", wr_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b expected 0", busy); else pass_cnt++;
    tick(2);
    rst = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    send_start();
    write_byte(8'h84, a);
    total_cnt++; if (a !== 1'b0) $display("FAIL rm_addr_ack: got %b expected 0", a); else pass_cnt++;
    write_byte(8'h77, a);
    send_stop();
    total_cnt++; if (wr_data !== 8'h77) $display("FAIL rm_wr_data_after: got %h expected 77", wr_data); else pass_cnt++;
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic a, s;
    logic [7:0] b;
    int w0;
    b = 8'h5A;
    w0 = wr_pulses;
    send_start();
    write_byte(8'h84, a);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i];
      tick(3);
      scl_m = 1'b1;
      tick(1);
      scl_m = 1'b0;
      tick(4);
      scl_m = 1'b1;
      tick(2 * Q);
      scl_m = 1'b0;
      tick(Q);
    end
    bus_bit(1'b0, s);
    send_stop();
    total_cnt++; if (s !== 1'b0) $display("FAIL gl_ack: got %b expected 0", s); else pass_cnt++;
    total_cnt++; if (wr_data !== 8'h5A) $display("FAIL gl_wr_data: got %h expected 5a", wr_data); else pass_cnt++;
    total_cnt++; if (wr_pulses - w0 !== 1) $display("FAIL gl_wr_valid: got %0d expected 1", wr_pulses - w0); else pass_cnt++;
  endtask
`endif

  initial begin
    rst     = 1'b1;
    scl_m   = 1'b1;
    m_low   = 1'b0;
    rd_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_repeated_start();
    test_reset_mid();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
